// File: rtl/packet_buffer_read_scheduler_if.sv
// -----------------------------------------------------------------------------
// packet_buffer_read_scheduler_if
//
// Bundles the buffer read port and the PacketPlayer delivery port seen by the
// read scheduler of one buffer partition.
//
//   pp_req     PP -> sched     per-PP level request for a packet
//   pb_ready   buf -> sched    per-FIFO non-empty flags
//   pb_select  sched -> buf    one-hot read select, pops the selected FIFO
//   pb_packet  buf -> sched    read data, valid one cycle after pb_select
//   pp_valid   sched -> PP     one-hot owner of the descriptor on pp_packet
//   pp_packet  sched -> PP     registered descriptor
//   pp_ack     PP -> sched     consume strobe, honoured only for the owner
//
// Modports: master = scheduler side, slave = buffer/PacketPlayer side.
// -----------------------------------------------------------------------------
interface packet_buffer_read_scheduler_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  logic [N-1:0]     pp_req;
  logic [N-1:0]     pb_ready;
  logic [N-1:0]     pb_select;
  logic [WIDTH-1:0] pb_packet;
  logic [N-1:0]     pp_valid;
  logic [WIDTH-1:0] pp_packet;
  logic [N-1:0]     pp_ack;

  modport master (
    input  pp_req,
    input  pb_ready,
    input  pb_packet,
    input  pp_ack,
    output pb_select,
    output pp_valid,
    output pp_packet
  );

  modport slave (
    output pp_req,
    output pb_ready,
    output pb_packet,
    output pp_ack,
    input  pb_select,
    input  pp_valid,
    input  pp_packet
  );
endinterface

// File: rtl/packet_buffer_read_scheduler.sv
// -----------------------------------------------------------------------------
// packet_buffer_read_scheduler
//
// Read-side scheduler for one packet buffer partition. Round-robin arbitrates
// among PacketPlayers whose request is up and whose FIFO is non-empty, pops
// the winner's FIFO with a one-cycle read select, captures the descriptor
// after the 1-cycle BRAM latency and offers it to the winner until acked.
//
// Ports:
//   i_clock         sole clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_enable        global run enable; low freezes FSM, pointer and counter
//   bus             packet_buffer_read_scheduler_if.master (see interface)
//   o_busy          FSM not in IDLE
//   o_grant_count   delivered (acked) packets, wraps modulo 2^CNT_W
//
// Per-packet timeline with enable high, candidate seen in IDLE at cycle T:
//   T+1 pb_select, T+2 capture of pb_packet, T+3 pp_valid, T+4 back in IDLE.
// -----------------------------------------------------------------------------
module packet_buffer_read_scheduler #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic                             i_enable,
  packet_buffer_read_scheduler_if.master   bus,
  output logic                             o_busy,
  output logic [CNT_W-1:0]                 o_grant_count
);

  localparam int RR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_OFFER
  } state_t;

  state_t           r_state;
  logic [RR_W-1:0]  r_rr;
  logic [RR_W-1:0]  r_winner;
  logic [N-1:0]     r_pp_valid;
  logic [WIDTH-1:0] r_pp_packet;
  logic [CNT_W-1:0] r_grant_count;

  logic [N-1:0]     w_cand;
  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_masked;
  logic             w_any;
  logic [RR_W-1:0]  w_pick;
  logic [RR_W-1:0]  w_next_rr;
  logic [N-1:0]     w_winner_oh;

  // Index of the lowest set bit; 0 when the vector is empty (caller gates).
  function automatic logic [RR_W-1:0] lowest_set(input logic [N-1:0] v);
    logic [RR_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = RR_W'(i);
    end
    return idx;
  endfunction

  // Round-robin search as a two-pass priority pick: first the candidates at
  // or above the pointer, and only if none exist the whole vector (the wrap).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_mask   = '0;
    w_cand   = bus.pp_req & bus.pb_ready;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i >= int'(r_rr));
    end
    w_masked = w_cand & w_mask;
    w_any    = |w_cand;
    w_pick   = (|w_masked) ? lowest_set(w_masked) : lowest_set(w_cand);
    w_next_rr = (w_pick == RR_W'(N - 1)) ? '0 : w_pick + RR_W'(1);
  end

  assign w_winner_oh = {{(N-1){1'b0}}, 1'b1} << r_winner;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_rr          <= '0;
      r_winner      <= '0;
      r_pp_valid    <= '0;
      // NOTE: the descriptor register is reset too: it is a single visible
      // output register, not a storage array, and must read 0 out of reset.
      r_pp_packet   <= '0;
      r_grant_count <= '0;
    end else if (i_enable) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the pre-edge values of its peers.
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_winner <= w_pick;
            r_rr     <= w_next_rr;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          // pb_select is driven this cycle; the buffer registers the address
          // on the closing edge and returns data during CAPTURE.
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_pp_packet <= bus.pb_packet;
          r_pp_valid  <= w_winner_oh;
          r_state     <= S_OFFER;
        end
        S_OFFER: begin
          // Only the owner's ack bit is looked at; everything else is noise.
          if (bus.pp_ack[r_winner]) begin
            r_pp_valid    <= '0;
            r_grant_count <= r_grant_count + CNT_W'(1);
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The pop must not fire while the FSM is frozen in FETCH, so the select is
  // qualified by the live enable rather than registered a cycle early.
  assign bus.pb_select = (r_state == S_FETCH && i_enable) ? w_winner_oh : '0;
  assign bus.pp_valid  = r_pp_valid;
  assign bus.pp_packet = r_pp_packet;
  assign o_busy        = (r_state != S_IDLE);
  assign o_grant_count = r_grant_count;

endmodule

// File: tb/tb_packet_buffer_read_scheduler.sv
// -----------------------------------------------------------------------------
// tb_packet_buffer_read_scheduler
//
// Directed plus randomized transactions against a transaction-level model:
// the model knows only the round-robin rule (first candidate from the pointer
// with wrap), the per-packet cycle timeline and the modular delivery count.
// Inputs are driven just after the falling edge, outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_packet_buffer_read_scheduler;

  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             o_busy;
  logic [CNT_W-1:0] o_grant_count;

  packet_buffer_read_scheduler_if #(.N(N), .WIDTH(WIDTH)) bus ();

  packet_buffer_read_scheduler #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_enable      (en),
    .bus           (bus),
    .o_busy        (o_busy),
    .o_grant_count (o_grant_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int m_rr   = 0;   // model round-robin pointer
  int m_cnt  = 0;   // model delivered-packet count (unbounded)

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // First candidate found scanning m_rr, m_rr+1, ... with wrap; -1 if none.
  function automatic int model_pick(input logic [N-1:0] cand);
    for (int k = 0; k < N; k++) begin
      if (cand[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_count(input string tag);
    check(tag, 64'(o_grant_count), 64'(m_cnt % CNT_MOD));
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    en = 1'b0;
    bus.pp_req = '0; bus.pb_ready = '0; bus.pp_ack = '0; bus.pb_packet = '0;
    #1;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_valid", 64'(bus.pp_valid), 64'd0);
    check("rst_count", 64'(o_grant_count), 64'd0);
    tick();
    rst_n = 1'b1;
    m_rr = 0;
    m_cnt = 0;
  endtask

  // One packet from IDLE back to IDLE.
  //   sf/sc/so : cycles with enable low in FETCH / CAPTURE / OFFER (so with all acks up)
  //   ad       : enable-high OFFER cycles carrying only non-owner acks
  //   drop     : withdraw pp_req right after the grant
  task automatic txn(input logic [N-1:0] req, input logic [N-1:0] rdy,
                     input logic [WIDTH-1:0] data, input int sf, input int sc,
                     input int ad, input int so, input bit drop);
    int w;
    logic [N-1:0] oh;
    tick();
    en = 1'b1; bus.pp_req = req; bus.pb_ready = rdy; bus.pp_ack = '0;
    bus.pb_packet = $urandom;
    #1;
    check("idle_busy", 64'(o_busy), 64'd0);
    check("idle_sel", 64'(bus.pb_select), 64'd0);
    check("idle_valid", 64'(bus.pp_valid), 64'd0);
    w = model_pick(req & rdy);
    if (w < 0) begin
      tick();
      bus.pp_req = '0;
      #1;
      check("nogrant_busy", 64'(o_busy), 64'd0);
      check("nogrant_sel", 64'(bus.pb_select), 64'd0);
      return;
    end
    oh = N'(1) << w;
    m_rr = (w + 1) % N;

    for (int s = 0; s < sf; s++) begin
      tick();
      en = 1'b0;
      if (drop) bus.pp_req = '0;
      #1;
      check("fetch_stall_sel", 64'(bus.pb_select), 64'd0);
      check("fetch_stall_busy", 64'(o_busy), 64'd1);
    end
    tick();
    en = 1'b1;
    if (drop) bus.pp_req = '0;
    #1;
    check("fetch_sel", 64'(bus.pb_select), 64'(oh));
    check("fetch_busy", 64'(o_busy), 64'd1);

    for (int s = 0; s < sc; s++) begin
      tick();
      en = 1'b0;
      bus.pb_packet = data;
      #1;
      check("cap_stall_sel", 64'(bus.pb_select), 64'd0);
      check("cap_stall_valid", 64'(bus.pp_valid), 64'd0);
    end
    tick();
    en = 1'b1;
    bus.pb_packet = data;
    #1;
    check("cap_sel", 64'(bus.pb_select), 64'd0);
    check("cap_valid", 64'(bus.pp_valid), 64'd0);

    for (int i = 0; i <= ad + so; i++) begin
      tick();
      bus.pb_packet = $urandom;
      if (i < ad) begin
        en = 1'b1;
        bus.pp_ack = N'($urandom) & ~oh;
      end else if (i < ad + so) begin
        en = 1'b0;
        bus.pp_ack = '1;
      end else begin
        en = 1'b1;
        bus.pp_ack = oh | N'($urandom);
      end
      #1;
      check("offer_valid", 64'(bus.pp_valid), 64'(oh));
      check("offer_packet", 64'(bus.pp_packet), 64'(data));
      check("offer_sel", 64'(bus.pb_select), 64'd0);
      check_count("offer_count");
    end
    m_cnt++;

    tick();
    bus.pp_ack = '0;
    bus.pp_req = '0;
    #1;
    check("done_valid", 64'(bus.pp_valid), 64'd0);
    check("done_busy", 64'(o_busy), 64'd0);
    check("done_packet_hold", 64'(bus.pp_packet), 64'(data));
    check_count("done_count");
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] rd;

    rst_n = 1'b0;
    en = 1'b0;
    bus.pp_req = '0; bus.pb_ready = '0; bus.pp_ack = '0; bus.pb_packet = '0;

    // Reset state, then 10 quiet cycles after release.
    repeat (3) tick();
    #1;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_sel", 64'(bus.pb_select), 64'd0);
    check("rst_packet", 64'(bus.pp_packet), 64'd0);
    rst_n = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      #1;
      check("quiet_busy", 64'(o_busy), 64'd0);
      check("quiet_sel", 64'(bus.pb_select), 64'd0);
      check("quiet_valid", 64'(bus.pp_valid), 64'd0);
      check("quiet_packet", 64'(bus.pp_packet), 64'd0);
      check("quiet_count", 64'(o_grant_count), 64'd0);
    end

    // Single PP2 delivery with immediate ack.
    txn(4'b0100, 4'b0100, 32'hCAFE0002, 0, 0, 0, 0, 1'b0);
    check("single_count", 64'(o_grant_count), 64'd1);

    // Round-robin 0,1,2,3,0 from a fresh pointer, then cand 1001 picks 3.
    do_reset();
    for (int g = 0; g < 5; g++) txn(4'b1111, 4'b1111, $urandom, 0, 0, 0, 0, 1'b0);
    txn(4'b1001, 4'b1111, $urandom, 0, 0, 0, 0, 1'b0);

    // Empty FIFO gating, and no grant when every FIFO is empty.
    txn(4'b1111, 4'b0010, $urandom, 0, 0, 0, 0, 1'b0);
    txn(4'b1111, 4'b0000, $urandom, 0, 0, 0, 0, 1'b0);

    // Stalls in every state and all-ones ack while frozen, owner PP1.
    txn(4'b0010, 4'b0010, 32'h5A5A1234, 2, 1, 1, 3, 1'b0);

    // Request withdrawn after the grant still gets its packet.
    txn(4'b1000, 4'b1000, 32'hDEAD0003, 1, 0, 2, 0, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      txn(N'($urandom), N'($urandom), $urandom, $urandom_range(0, 2),
          $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 2),
          1'($urandom_range(0, 1)));
    end

    // Counter wrap: 17 deliveries with a 4-bit counter.
    do_reset();
    for (int t = 0; t < 17; t++) begin
      rq = N'($urandom);
      rd = N'($urandom);
      if ((rq & rd) == '0) begin
        rq = rq | rd | N'(1);
        rd = rd | N'(1);
      end
      txn(rq, rd, $urandom, 0, 0, $urandom_range(0, 1), 0, 1'($urandom_range(0, 1)));
    end
    check("wrap_count", 64'(o_grant_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
